// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side drain stage: skid occupancy encoding and depth.
package fifo_rd_pkg;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry head/tail skid buffer with its occupancy state machine.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output occ_t                  occ,
  output logic [DATA_WIDTH-1:0] head
);

  occ_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            tail_d  = push_data;
            state_d = TWO;
          end
          2'b01: state_d = EMPTY;
          // Head leaves and the new word takes its place in one cycle.
          2'b11: head_d = push_data;
          default: state_d = ONE;
        endcase
      end
      TWO: begin
        // The read credit guarantees no push arrives while both entries are full.
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign occ  = state_q;
  assign head = head_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-domain drain: credit-based FIFO read issue, one-cycle read latency absorption, skid output.
// Optional FIFO_RD_COUNT_EN adds the rd_count delivered-word counter.
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_RD_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

  occ_t       occ;
  logic [1:0] occ_n;
  logic [2:0] credit;
  logic       pop;
  logic       inflight_q, inflight_d;

  assign occ_n   = occ;
  assign m_valid = (occ != EMPTY);
  assign pop     = m_valid & m_ready;

  // Words already buffered or in flight, minus the one leaving this cycle.
  assign credit     = {1'b0, occ_n} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_r_en  = ~r_rst & ~fifo_empty & (credit < 3'(SKID_DEPTH));
  assign inflight_d = fifo_r_en & ~fifo_empty;

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  fifo_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .r_clk    (r_clk),
    .r_rst    (r_rst),
    .push     (inflight_q),
    .push_data(fifo_r_data),
    .pop      (pop),
    .occ      (occ),
    .head     (m_data)
  );

`ifdef FIFO_RD_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pop) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_count = cnt_q;
`else
  logic [CNT_WIDTH-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Self-checking bench for fifo_rd_drain: behavioural FIFO model feeding a scoreboard of expected words.
module tb_fifo_rd_drain;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          r_clk = 1'b0;
  logic          r_rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_r_data = '0;
  logic          fifo_r_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b1;
`ifdef FIFO_RD_COUNT_EN
  logic [CW-1:0] rd_count;
`endif

  logic          hold_empty = 1'b0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            pop_cnt = 0;
  int            checks = 0;
  int            errors = 0;

  fifo_rd_drain #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .r_clk      (r_clk),
    .r_rst      (r_rst),
    .fifo_empty (fifo_empty),
    .fifo_r_data(fifo_r_data),
    .fifo_r_en  (fifo_r_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
`ifdef FIFO_RD_COUNT_EN
    ,
    .rd_count   (rd_count)
`endif
  );

  always #5 r_clk = ~r_clk;

  // FIFO model on the rising edge, output scoreboard on the falling edge.
  always begin
    logic [DW-1:0] w;
    logic [DW-1:0] e;
    @(posedge r_clk);
    if (r_rst) begin
      exp_q.delete();
      pop_cnt = 0;
    end
    if (fifo_r_en && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      exp_q.push_back(w);
      fifo_r_data <= w;
    end else begin
      fifo_r_data <= '0;
    end
    fifo_empty <= hold_empty || (fifo_q.size() == 0);
    @(negedge r_clk);
    if (!r_rst && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got %h, required no word", m_data);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e) begin
          errors++;
          $display("FAIL sb_data: got %h, required %h", m_data, e);
        end
      end
      pop_cnt++;
    end
  end

  task automatic test_reset();
    logic [DW-1:0] words[3];
    words[0] = 8'hA1;
    words[1] = 8'hB2;
    words[2] = 8'hC3;
    r_rst   = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) fifo_q.push_back(words[i]);
    for (int i = 0; i < 3; i++) begin
      @(negedge r_clk);
      checks++;
      if (fifo_r_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0) begin
        errors++;
        $display("FAIL reset_hold: got r_en=%b valid=%b data=%h, required 0 0 00", fifo_r_en, m_valid, m_data);
      end
    end
    @(posedge r_clk); #1;
    r_rst = 1'b0;
    @(negedge r_clk);
    checks++;
    if (fifo_r_en !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_read: got r_en=%b valid=%b, required 1 0", fifo_r_en, m_valid);
    end
    @(negedge r_clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_latency: got valid=%b, required 0", m_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge r_clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== words[i]) begin
        errors++;
        $display("FAIL reset_word%0d: got valid=%b data=%h, required 1 %h", i, m_valid, m_data, words[i]);
      end
    end
    @(negedge r_clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_tail: got valid=%b, required 0", m_valid);
    end
  endtask

  task automatic test_stream();
    int start;
    int runs;
    @(posedge r_clk); #1;
    m_ready = 1'b1;
    start   = pop_cnt;
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'(8'h10 + i));
    for (int i = 0; i < 10 && !m_valid; i++) @(negedge r_clk);
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL stream_start: got valid=%b, required 1", m_valid);
    end
    runs = 0;
    while (m_valid && runs < 40) begin
      runs++;
      @(negedge r_clk);
    end
    checks++;
    if (runs != 16 || pop_cnt - start != 16) begin
      errors++;
      $display("FAIL stream_run: got %0d valid cycles %0d pops, required 16 16", runs, pop_cnt - start);
    end
`ifdef FIFO_RD_COUNT_EN
    checks++;
    if (rd_count !== CW'(pop_cnt)) begin
      errors++;
      $display("FAIL stream_count: got %0d, required %0d", rd_count, CW'(pop_cnt));
    end
`endif
  endtask

  task automatic test_backpressure();
    int start;
    int issued;
    @(posedge r_clk); #1;
    m_ready = 1'b0;
    start   = pop_cnt;
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'(8'h20 + i));
    issued = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge r_clk);
      if (fifo_r_en) issued++;
    end
    checks++;
    if (issued != 2 || fifo_r_en !== 1'b0) begin
      errors++;
      $display("FAIL bp_reads: got %0d reads r_en=%b, required 2 0", issued, fifo_r_en);
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h20) begin
      errors++;
      $display("FAIL bp_hold: got valid=%b data=%h, required 1 20", m_valid, m_data);
    end
    @(posedge r_clk); #1;
    m_ready = 1'b1;
    for (int i = 0; i < 60 && (pop_cnt - start) < 10; i++) @(negedge r_clk);
    @(negedge r_clk);
    checks++;
    if (pop_cnt - start != 10 || exp_q.size() != 0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got %0d pops %0d pending valid=%b, required 10 0 0", pop_cnt - start, exp_q.size(), m_valid);
    end
  endtask

  task automatic test_toggle();
    int start;
    start = pop_cnt;
    @(posedge r_clk); #1;
    for (int i = 0; i < 12; i++) fifo_q.push_back(8'(8'h40 + i));
    for (int cyc = 0; cyc < 200 && (pop_cnt - start) < 12; cyc++) begin
      @(posedge r_clk); #1;
      m_ready    = (cyc % 2 == 0);
      hold_empty = (cyc % 3 == 1);
      @(negedge r_clk);
    end
    @(posedge r_clk); #1;
    hold_empty = 1'b0;
    m_ready    = 1'b1;
    repeat (4) @(negedge r_clk);
    checks++;
    if (pop_cnt - start != 12 || exp_q.size() != 0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL toggle_total: got %0d pops %0d pending valid=%b, required 12 0 0", pop_cnt - start, exp_q.size(), m_valid);
    end
  endtask

  task automatic test_reset_inflight();
    @(posedge r_clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h60 + i));
    for (int i = 0; i < 10 && !m_valid; i++) @(negedge r_clk);
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_fly_setup: got valid=%b, required 1", m_valid);
    end
    r_rst = 1'b1;
    #1;
    checks++;
    if (fifo_r_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_fly_ren: got %b, required 0", fifo_r_en);
    end
    @(posedge r_clk); #1;
    r_rst = 1'b0;
    @(negedge r_clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_fly_valid: got %b, required 0", m_valid);
    end
`ifdef FIFO_RD_COUNT_EN
    checks++;
    if (rd_count !== '0) begin
      errors++;
      $display("FAIL rst_fly_count: got %0d, required 0", rd_count);
    end
`endif
    @(posedge r_clk); #1;
    m_ready = 1'b1;
    for (int i = 0; i < 40 && pop_cnt < 4; i++) @(negedge r_clk);
    repeat (3) @(negedge r_clk);
    checks++;
    if (pop_cnt != 4 || exp_q.size() != 0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_fly_rest: got %0d pops %0d pending, required 4 0", pop_cnt, exp_q.size());
    end
`ifdef FIFO_RD_COUNT_EN
    checks++;
    if (rd_count !== CW'(4)) begin
      errors++;
      $display("FAIL rst_fly_count_after: got %0d, required 4", rd_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_reset_inflight();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side drain stage sitting directly downstream of the asynchronous FIFO, entirely in the read clock domain. It issues `r_en` pulses to the FIFO, absorbs the FIFO's one-cycle registered read latency, and presents the words on a valid/ready stream with a 2-entry skid buffer. It sustains one word per cycle under continuous `m_ready` and never drops or duplicates a word.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: word width; must match the FIFO.
- `CNT_WIDTH`, default 16: width of the delivered-word counter. Used only with `FIFO_RD_COUNT_EN`.

Ports:
- `r_clk`, input, 1: read-domain clock. All logic is on the rising edge.
- `r_rst`, input, 1: reset. Synchronous and active-high.
- `fifo_empty`, input, 1: the FIFO's `empty` flag.
- `fifo_r_data`, input, `DATA_WIDTH`: the FIFO's `r_data`. It is valid the cycle after an accepted read.
- `fifo_r_en`, output, 1: read request to the FIFO.
- `m_valid`, output, 1: output word valid.
- `m_data`, output, `DATA_WIDTH`: output word.
- `m_ready`, input, 1: downstream accepts the word.
- `rd_count`, output, `CNT_WIDTH`: words delivered. Present only with `FIFO_RD_COUNT_EN`.

## Operation

Definitions:
- `pop = m_valid & m_ready`.
- `fire = fifo_r_en & ~fifo_empty`, the accepted FIFO read.
- `inflight` is a register that holds the value of `fire` from the previous cycle.
- `occ` is the number of buffer entries in use, 0 to 2.

Read issue:
- `fifo_r_en = ~r_rst & ~fifo_empty & ((occ + inflight - pop) < 2)`.
- The request is combinational, so the occupancy credit is never exceeded.

Capture:
- When `inflight` = 1, `fifo_r_data` is written into the buffer tail on that edge.
- The FIFO drives `r_data` to 0 on non-read cycles. Data must therefore be captured only when `inflight` = 1, never at any other time.

Occupancy state machine (states EMPTY, ONE, TWO):
- EMPTY: goes to ONE on capture.
- ONE: goes to TWO on capture without pop; goes to EMPTY on pop without capture; stays in ONE on capture with pop.
- TWO: goes to ONE on pop. A capture cannot occur in TWO, because the credit rule forbids it.

Output:
- `m_valid = (occ != 0)`.
- `m_data` is the buffer head register. It is stable while `m_valid & ~m_ready` (AXI-style hold).

Ordering:
- Strict FIFO order.
- When a pop and a capture happen in the same cycle, the head shifts and the tail loads in that one cycle.

Reset:
- All of the following clear on any `r_clk` edge with `r_rst` = 1: `occ` = 0, `inflight` = 0, `m_valid` = 0, `m_data` = 0, `rd_count` = 0, `fifo_r_en` = 0.
- A word in flight at reset is discarded. The FIFO's `r_rst` must be asserted together with this block's reset, so the FIFO pointer and this block stay consistent.

## Timing

- Latency: `fifo_empty` falls in cycle T, so `fifo_r_en` = 1 in T; the word is captured at the end of T+1; `m_valid` = 1 in T+2.
- Throughput: 1 word per cycle with `m_ready` held at 1 and the FIFO non-empty.
- Backpressure: with `m_ready` = 0, reads stop once `occ + inflight` = 2. At most 2 words are buffered. Nothing is lost.
- `fifo_empty` asserting the same cycle as a `fifo_r_en`: that cycle's `fire` = 0. No capture happens in the next cycle.

## Configuration

- `FIFO_RD_COUNT_EN` defined:
  - Adds the `rd_count` port.
  - `rd_count` increments by 1 on every `pop`.
  - It wraps modulo 2^`CNT_WIDTH`.
  - It resets to 0.
- `FIFO_RD_COUNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure

- Shared package `fifo_rd_pkg` holds:
  - `typedef enum {EMPTY, ONE, TWO} occ_t`
  - `localparam SKID_DEPTH = 2`
- Sub-module `fifo_rd_skid`: the 2-entry head/tail buffer and the occupancy FSM. Its ports are `push` with its data, and `pop`, `occ`, `head`.
- The top level holds the credit logic, the `inflight` register and the optional counter.

## Test plan

- Reset with the FIFO holding 3 words: during reset `fifo_r_en` = 0 and `m_valid` = 0. After release, words A, B, C appear on cycles T+2, T+3, T+4 with `m_ready` = 1.
- Stream 16 words with `m_ready` = 1: 16 consecutive `m_valid` cycles, in order, with no gaps after the first. With the macro, `rd_count` = 16.
- `m_ready` = 0 with 10 words in the FIFO: exactly 2 reads are issued, then `fifo_r_en` stays 0. `m_data` holds the first word. Releasing `m_ready` yields all 10 in order.
- Toggle `m_ready` 1,0,1,0 while `fifo_empty` toggles: no word is duplicated or dropped, and a 0 from the FIFO's idle `r_data` never appears as a valid word.
- Assert `r_rst` for 1 cycle while `inflight` = 1 and `occ` = 2: the next cycle has `m_valid` = 0, `occ` = 0 and `rd_count` = 0.
- `CNT_WIDTH` = 4, 17 pops: `rd_count` wraps to 1.
